// File: rtl/wb_regfile_if.sv
// W-stage bundle for the writeback register file: commit inputs, decode read
// ports and the exported writeback result.
interface wb_regfile_if #(
    parameter int XLEN = 32
);
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;
    logic [4:0]      RdW;
    logic [4:0]      A1;
    logic [4:0]      A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] ResultW;
    logic            WbValidW;

    modport master (
        output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1, A2,
        input  RD1, RD2, ResultW, WbValidW
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1, A2,
        output RD1, RD2, ResultW, WbValidW
    );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback stage: result mux, commit to the architectural register file,
// and two decode read ports with write-first bypass.
module wb_regfile #(
    parameter int              XLEN        = 32,
    parameter int              NREG        = 32,
    parameter logic [XLEN-1:0] RESET_VALUE = '0,
    parameter logic [XLEN-1:0] SP_RESET    = 32'h1000_7FFC
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam logic [5:0] NREG_W = 6'(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rd_in_range;
    logic            a1_in_range;
    logic            a2_in_range;
    logic            we;

    always_comb begin
        result = '0;
        case (bus.ResultSrcW)
            2'b00:   result = bus.ALUResultW;
            2'b01:   result = bus.ReadDataW;
            2'b10:   result = bus.PCPlus4W;
            default: result = '0;
        endcase
    end

    assign rd_in_range = ({1'b0, bus.RdW} < NREG_W);
    assign a1_in_range = ({1'b0, bus.A1} < NREG_W);
    assign a2_in_range = ({1'b0, bus.A2} < NREG_W);

    // Reset also masks the commit, which in turn disables the bypass.
    assign we = bus.RegWriteW && (bus.RdW != 5'd0) && (bus.ResultSrcW != 2'b11)
                && !rst && rd_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 0)
                    regs[i] <= '0;
                else if (i == 2)
                    regs[i] <= SP_RESET;
                else
                    regs[i] <= RESET_VALUE;
            end
        end else if (we) begin
            regs[bus.RdW] <= result;
        end
    end

    always_comb begin
        rd1 = '0;
        if (bus.A1 != 5'd0 && a1_in_range)
            rd1 = (we && bus.A1 == bus.RdW) ? result : regs[bus.A1];
    end

    always_comb begin
        rd2 = '0;
        if (bus.A2 != 5'd0 && a2_in_range)
            rd2 = (we && bus.A2 == bus.RdW) ? result : regs[bus.A2];
    end

    assign bus.RD1      = rd1;
    assign bus.RD2      = rd2;
    assign bus.ResultW  = result;
    assign bus.WbValidW = we;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected outputs, a monitor
// samples the DUT on the falling edge and compares.
module tb_wb_regfile;
    localparam int SEL_RESULT = 0;
    localparam int SEL_VALID  = 1;
    localparam int SEL_RD1    = 2;
    localparam int SEL_RD2    = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_failed   = 0;

    wb_regfile_if #(.XLEN(32)) bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string name, input int sel, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.sel   = sel;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [1:0] src,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst            = r;
        bus.RegWriteW  = we;
        bus.ResultSrcW = src;
        bus.RdW        = rd;
        bus.ALUResultW = alu;
        bus.A1         = a1;
        bus.A2         = a2;
    endtask

    // Monitor: every queued expectation belongs to the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.sel)
                    SEL_RESULT: act = bus.ResultW;
                    SEL_VALID:  act = {31'd0, bus.WbValidW};
                    SEL_RD1:    act = bus.RD1;
                    default:    act = bus.RD2;
                endcase
                n_compared++;
                if (act !== e.value) begin
                    n_failed++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.value);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bus.ReadDataW = 32'h0;
        bus.PCPlus4W  = 32'h0;

        // Reset edge with a concurrent write that must be dropped.
        drive(1'b1, 1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd2);
        #1;
        push_exp("valid_in_reset", SEL_VALID, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd2);
        push_exp("reset_x5", SEL_RD1, 32'h0);
        push_exp("reset_sp", SEL_RD2, 32'h1000_7FFC);

        // Mux select 00 / 01 / 10, each committed to x3.
        next_cycle();
        drive(1'b0, 1'b1, 2'b00, 5'd3, 32'h11, 5'd3, 5'd0);
        push_exp("alu_result", SEL_RESULT, 32'h11);
        push_exp("alu_valid",  SEL_VALID,  32'd1);
        push_exp("alu_bypass", SEL_RD1,    32'h11);
        next_cycle();
        bus.RegWriteW = 1'b0;
        push_exp("alu_commit", SEL_RD1, 32'h11);

        next_cycle();
        bus.ReadDataW = 32'h22;
        drive(1'b0, 1'b1, 2'b01, 5'd3, 32'h77, 5'd3, 5'd0);
        push_exp("load_result", SEL_RESULT, 32'h22);
        push_exp("load_valid",  SEL_VALID,  32'd1);
        next_cycle();
        bus.RegWriteW = 1'b0;
        push_exp("load_commit", SEL_RD1, 32'h22);

        next_cycle();
        bus.PCPlus4W = 32'h1000_0008;
        drive(1'b0, 1'b1, 2'b10, 5'd3, 32'h77, 5'd3, 5'd0);
        push_exp("pc4_result", SEL_RESULT, 32'h1000_0008);
        push_exp("pc4_valid",  SEL_VALID,  32'd1);
        next_cycle();
        bus.RegWriteW = 1'b0;
        push_exp("pc4_commit", SEL_RD1, 32'h1000_0008);

        // Bypass on x7: no write returns old value, write returns ResultW on both ports.
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
        push_exp("nobyp_rd1", SEL_RD1, 32'h0);
        push_exp("nobyp_rd2", SEL_RD2, 32'h0);
        next_cycle();
        bus.RegWriteW = 1'b1;
        push_exp("byp_rd1", SEL_RD1, 32'hA5A5_A5A5);
        push_exp("byp_rd2", SEL_RD2, 32'hA5A5_A5A5);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
        push_exp("x7_old_rd1", SEL_RD1, 32'hA5A5_A5A5);
        push_exp("x7_old_rd2", SEL_RD2, 32'hA5A5_A5A5);

        // x0 protection.
        next_cycle();
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd7);
        push_exp("x0_result", SEL_RESULT, 32'hFFFF_FFFF);
        push_exp("x0_valid",  SEL_VALID,  32'd0);
        push_exp("x0_same",   SEL_RD1,    32'h0);
        next_cycle();
        bus.RegWriteW = 1'b0;
        push_exp("x0_next", SEL_RD1, 32'h0);

        // Reserved select suppresses the commit and the bypass.
        next_cycle();
        drive(1'b0, 1'b1, 2'b11, 5'd9, 32'h99, 5'd9, 5'd0);
        push_exp("rsv_result", SEL_RESULT, 32'h0);
        push_exp("rsv_valid",  SEL_VALID,  32'd0);
        push_exp("rsv_nobyp",  SEL_RD1,    32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd9, 32'h99, 5'd9, 5'd0);
        push_exp("rsv_x9_held", SEL_RD1, 32'h0);

        // Back-to-back commits to x4, then reset with a concurrent write.
        next_cycle();
        drive(1'b0, 1'b1, 2'b00, 5'd4, 32'h1, 5'd4, 5'd3);
        push_exp("b2b_first_byp", SEL_RD1, 32'h1);
        next_cycle();
        bus.ALUResultW = 32'h2;
        push_exp("b2b_second_byp", SEL_RD1, 32'h2);
        next_cycle();
        bus.RegWriteW = 1'b0;
        push_exp("b2b_last_wins", SEL_RD1, 32'h2);
        push_exp("x3_before_rst", SEL_RD2, 32'h1000_0008);
        next_cycle();
        drive(1'b1, 1'b1, 2'b00, 5'd4, 32'h3, 5'd4, 5'd3);
        push_exp("midrst_valid",    SEL_VALID, 32'd0);
        push_exp("midrst_pre_x4",   SEL_RD1,   32'h2);
        push_exp("midrst_pre_x3",   SEL_RD2,   32'h1000_0008);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd4, 32'h3, 5'd4, 5'd2);
        push_exp("midrst_x4_reset", SEL_RD1, 32'h0);
        push_exp("midrst_sp_reset", SEL_RD2, 32'h1000_7FFC);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd4, 32'h3, 5'd3, 5'd7);
        push_exp("midrst_x3_reset", SEL_RD1, 32'h0);
        push_exp("midrst_x7_reset", SEL_RD2, 32'h0);

        next_cycle();
        next_cycle();
        if (exp_q.size() != 0) begin
            n_compared++;
            n_failed++;
            $display("FAIL queue_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
